mux_scan_nto1: RTL



---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux_nto1.sv | 28 ++
 rtl/mux_scan_nto1.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared types and constants for the N-to-1 fixed/scan multiplexer.
//   - state_e    : controller states (IDLE, SCAN, DONE)
//   - MODE_FIXED : mode input value selecting channel s every free cycle
//   - MODE_SCAN  : mode input value enabling start-triggered channel scans
//   - sel_width  : channel index width for a given channel count (min 1)
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    function automatic int sel_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// mux_nto1
//   Purely combinational N-to-1 channel selector.
//   Ports:
//     d_i   [N_CH*W-1:0] packed channel data, channel k at d_i[k*W +: W]
//     idx_i [SEL_W-1:0]  channel index
//     q_o   [W-1:0]      selected channel, zero when idx_i >= N_CH
module mux_nto1 #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = 3
) (
    input  logic [N_CH*W-1:0] d_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic [W-1:0]      q_o
);

    // An index with no matching channel leaves the zero default in place,
    // which covers the out-of-range case for non power-of-two N_CH.
    always_comb begin
        q_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx_i) == k) begin
                q_o = d_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1
//   N-to-1 multiplexer with a registered output slot and two modes:
//   fixed-select (load channel s every free cycle) and scan (on start, walk
//   channels 0..N_CH-1 once, emitting only channels whose d_vld is set,
//   honouring downstream backpressure, then pulse done).
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     d      [N_CH*W-1:0] packed channel data, channel k at d[k*W +: W]
//     d_vld  [N_CH-1:0]   per-channel data-present flags
//     mode   0 = fixed-select, 1 = scan (sampled in IDLE only)
//     s      [SEL_W-1:0]  fixed-mode channel select
//     start  begins a scan (IDLE with mode=1 only)
//     y      [W-1:0]      registered selected data
//     y_ch   [SEL_W-1:0]  channel index of the data in y
//     y_vld  output slot valid
//     y_rdy  downstream ready
//     busy   high while scanning
//     done   one-cycle pulse at the end of a scan
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 1,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] d,
    input  logic [N_CH-1:0]   d_vld,
    input  logic              mode,
    input  logic [SEL_W-1:0]  s,
    input  logic              start,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_ch,
    output logic              y_vld,
    input  logic              y_rdy,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   y_ch_q, y_ch_d;
    logic               y_vld_q, y_vld_d;

    logic               slot_free;
    logic [SEL_W-1:0]   idx;
    logic [W-1:0]       sel_dat;
    logic               sel_vld;
    logic               last_ch;

    // Slot can accept new data if empty or being drained this cycle.
    assign slot_free = ~y_vld_q | y_rdy;

    // Single index mux shared by both paths: scan pointer while scanning,
    // external select otherwise.
    assign idx     = (state_q == ST_SCAN) ? ptr_q : s;
    assign last_ch = (ptr_q == SEL_W'(N_CH - 1));

    mux_nto1 #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) u_sel_dat (
        .d_i   (d),
        .idx_i (idx),
        .q_o   (sel_dat)
    );

    mux_nto1 #(.N_CH(N_CH), .W(1), .SEL_W(SEL_W)) u_sel_vld (
        .d_i   (d_vld),
        .idx_i (idx),
        .q_o   (sel_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        y_ch_d  = y_ch_q;
        y_vld_d = y_vld_q;

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_FIXED) begin
                    if (slot_free) begin
                        y_d     = sel_dat;
                        y_ch_d  = s;
                        y_vld_d = sel_vld;
                    end
                end else if (start) begin
                    // Slot deliberately left untouched on the start cycle.
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                end else if (slot_free) begin
                    y_vld_d = 1'b0;
                end
            end

            ST_SCAN: begin
                if (!sel_vld || slot_free) begin
                    if (sel_vld) begin
                        y_d     = sel_dat;
                        y_ch_d  = ptr_q;
                        y_vld_d = 1'b1;
                    end else if (slot_free) begin
                        // Drained word is not re-presented while skipping.
                        y_vld_d = 1'b0;
                    end
                    // Pointer parks on the last channel rather than wrapping.
                    if (last_ch) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + SEL_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (slot_free) begin
                    y_vld_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            y_q     <= '0;
            y_ch_q  <= '0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            y_ch_q  <= y_ch_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign y     = y_q;
    assign y_ch  = y_ch_q;
    assign y_vld = y_vld_q;
    assign busy  = (state_q == ST_SCAN);
    assign done  = (state_q == ST_DONE);

endmodule
